// File: rtl/slide_intf.sv
// Slide-pot A2D interface: a 16-bit SPI master, a two-frame conversion sequencer
// and a round-robin scheduler that keeps six pot/volume readings current.
module slide_intf (
    input  logic        clk,
    input  logic        rst_n,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic [11:0] POT_LP,
    output logic [11:0] POT_B1,
    output logic [11:0] POT_B2,
    output logic [11:0] POT_B3,
    output logic [11:0] POT_HP,
    output logic [11:0] VOLUME
);

    typedef enum logic [1:0] {SPI_IDLE, SPI_PORCH, SPI_SHIFT} spi_state_t;
    typedef enum logic [1:0] {SEQ_IDLE, SEQ_CMD, SEQ_WAIT, SEQ_READ} seq_state_t;

    localparam logic [4:0] DIV_LOAD = 5'b10111;
    localparam logic [4:0] DIV_SMPL = 5'b01111;
    localparam logic [4:0] DIV_SHFT = 5'b11111;

    // Scheduler slot to A2D channel number.
    function automatic logic [2:0] chnl_of(input logic [2:0] ptr);
        case (ptr)
            3'd0:    chnl_of = 3'd1;
            3'd1:    chnl_of = 3'd0;
            3'd2:    chnl_of = 3'd4;
            3'd3:    chnl_of = 3'd2;
            3'd4:    chnl_of = 3'd3;
            3'd5:    chnl_of = 3'd7;
            default: chnl_of = 3'd1;
        endcase
    endfunction

    spi_state_t  spi_state_r, spi_state_s;
    seq_state_t  seq_state_r, seq_state_s;
    logic [4:0]  div_r;
    logic [15:0] shft_r;
    logic [3:0]  bit_cnt_r;
    logic        smpl_r;
    logic        ss_n_r;
    logic        done_r;
    logic        miso_meta_r;
    logic        miso_sync_r;
    logic [2:0]  ptr_r;
    logic [11:0] pot_lp_r, pot_b1_r, pot_b2_r, pot_b3_r, pot_hp_r, volume_r;

    logic        ld_s, smpl_s, shft_s, fin_s;
    logic        wrt_s, cnv_cmplt_s, strt_cnv_s;
    logic [15:0] cmd_s;

    // The scheduler never pauses: a new conversion is requested whenever the sequencer is idle.
    assign strt_cnv_s = 1'b1;
    assign cmd_s      = {2'b00, chnl_of(ptr_r), 11'h000};

    assign SS_n   = ss_n_r;
    assign SCLK   = div_r[4];
    assign MOSI   = shft_r[15];
    assign POT_LP = pot_lp_r;
    assign POT_B1 = pot_b1_r;
    assign POT_B2 = pot_b2_r;
    assign POT_B3 = pot_b3_r;
    assign POT_HP = pot_hp_r;
    assign VOLUME = volume_r;

    // Two-flop synchroniser; MISO settles 16 clks before it is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_meta_r <= 1'b0;
            miso_sync_r <= 1'b0;
        end else begin
            miso_meta_r <= MISO;
            miso_sync_r <= miso_meta_r;
        end
    end

    // SPI master next state and datapath strobes.
    always_comb begin
        spi_state_s = spi_state_r;
        ld_s        = 1'b0;
        smpl_s      = 1'b0;
        shft_s      = 1'b0;
        fin_s       = 1'b0;
        case (spi_state_r)
            SPI_IDLE: begin
                if (wrt_s) begin
                    ld_s        = 1'b1;
                    spi_state_s = SPI_PORCH;
                end else begin
                    spi_state_s = SPI_IDLE;
                end
            end
            SPI_PORCH: begin
                // The first SCLK fall only ends the front porch.
                if (div_r == DIV_SHFT) begin
                    spi_state_s = SPI_SHIFT;
                end else begin
                    spi_state_s = SPI_PORCH;
                end
            end
            SPI_SHIFT: begin
                if (div_r == DIV_SMPL) begin
                    smpl_s = 1'b1;
                end else begin
                    smpl_s = 1'b0;
                end
                if (div_r == DIV_SHFT) begin
                    shft_s = 1'b1;
                    if (bit_cnt_r == 4'd15) begin
                        fin_s       = 1'b1;
                        spi_state_s = SPI_IDLE;
                    end else begin
                        spi_state_s = SPI_SHIFT;
                    end
                end else begin
                    shft_s = 1'b0;
                end
            end
            default: begin
                spi_state_s = SPI_IDLE;
            end
        endcase
    end

    // SPI master state, divider, shift register and frame control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_state_r <= SPI_IDLE;
            div_r       <= DIV_LOAD;
            shft_r      <= 16'h0000;
            bit_cnt_r   <= 4'd0;
            smpl_r      <= 1'b0;
            ss_n_r      <= 1'b1;
            done_r      <= 1'b0;
        end else begin
            spi_state_r <= spi_state_s;
            done_r      <= fin_s;
            if (ld_s) begin
                div_r     <= DIV_LOAD;
                shft_r    <= cmd_s;
                bit_cnt_r <= 4'd0;
                ss_n_r    <= 1'b0;
            end else if (fin_s) begin
                // Last shift replaces the final fall: reload keeps SCLK high while SS_n releases.
                div_r     <= DIV_LOAD;
                shft_r    <= {shft_r[14:0], smpl_r};
                bit_cnt_r <= 4'd0;
                ss_n_r    <= 1'b1;
            end else begin
                if (spi_state_r != SPI_IDLE) begin
                    div_r <= div_r + 5'd1;
                end
                if (smpl_s) begin
                    smpl_r <= miso_sync_r;
                end
                if (shft_s) begin
                    shft_r    <= {shft_r[14:0], smpl_r};
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                end
            end
        end
    end

    // Conversion sequencer: command frame, one-clk gap, read frame.
    always_comb begin
        seq_state_s = seq_state_r;
        wrt_s       = 1'b0;
        cnv_cmplt_s = 1'b0;
        case (seq_state_r)
            SEQ_IDLE: begin
                if (strt_cnv_s) begin
                    wrt_s       = 1'b1;
                    seq_state_s = SEQ_CMD;
                end else begin
                    seq_state_s = SEQ_IDLE;
                end
            end
            SEQ_CMD: begin
                if (done_r) begin
                    seq_state_s = SEQ_WAIT;
                end else begin
                    seq_state_s = SEQ_CMD;
                end
            end
            SEQ_WAIT: begin
                wrt_s       = 1'b1;
                seq_state_s = SEQ_READ;
            end
            SEQ_READ: begin
                if (done_r) begin
                    cnv_cmplt_s = 1'b1;
                    seq_state_s = SEQ_IDLE;
                end else begin
                    seq_state_s = SEQ_READ;
                end
            end
            default: begin
                seq_state_s = SEQ_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_state_r <= SEQ_IDLE;
        end else begin
            seq_state_r <= seq_state_s;
        end
    end

    // Scheduler: load only the finished channel's output, then advance the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r    <= 3'd0;
            pot_lp_r <= 12'h000;
            pot_b1_r <= 12'h000;
            pot_b2_r <= 12'h000;
            pot_b3_r <= 12'h000;
            pot_hp_r <= 12'h000;
            volume_r <= 12'h000;
        end else if (cnv_cmplt_s) begin
            case (ptr_r)
                3'd0:    pot_lp_r <= shft_r[11:0];
                3'd1:    pot_b1_r <= shft_r[11:0];
                3'd2:    pot_b2_r <= shft_r[11:0];
                3'd3:    pot_b3_r <= shft_r[11:0];
                3'd4:    pot_hp_r <= shft_r[11:0];
                3'd5:    volume_r <= shft_r[11:0];
                default: pot_lp_r <= pot_lp_r;
            endcase
            if (ptr_r >= 3'd5) begin
                ptr_r <= 3'd0;
            end else begin
                ptr_r <= ptr_r + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_slide_intf.sv
// Bench for slide_intf: an A2D SPI slave model feeds pot values; a scoreboard
// checks each conversion result, command words and SPI framing.
module tb_slide_intf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MISO = 1'b0;
    logic        SS_n, SCLK, MOSI;
    logic [11:0] POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME;

    always #5 clk = ~clk;

    slide_intf dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .SS_n   (SS_n),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .MISO   (MISO),
        .POT_LP (POT_LP),
        .POT_B1 (POT_B1),
        .POT_B2 (POT_B2),
        .POT_B3 (POT_B3),
        .POT_HP (POT_HP),
        .VOLUME (VOLUME)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [11:0] pot_v [0:7];
    logic [2:0]  order [0:5] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

    function automatic logic [11:0] out_of(input int idx);
        case (idx)
            0:       return POT_LP;
            1:       return POT_B1;
            2:       return POT_B2;
            3:       return POT_B3;
            4:       return POT_HP;
            default: return VOLUME;
        endcase
    endfunction

    task automatic set_pots(input logic [11:0] lp, input logic [11:0] b1, input logic [11:0] b2,
                            input logic [11:0] b3, input logic [11:0] hp, input logic [11:0] vol);
        pot_v[1] = lp;
        pot_v[0] = b1;
        pot_v[4] = b2;
        pot_v[2] = b3;
        pot_v[3] = hp;
        pot_v[7] = vol;
        pot_v[5] = 12'h000;
        pot_v[6] = 12'h000;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 6; i++) begin
            chk(tag, 32'(out_of(i)), 32'(pot_v[order[i]]));
        end
    endtask

    typedef struct packed {
        logic [2:0]  idx;
        logic [11:0] val;
    } exp_t;

    exp_t        sb_q [$];
    logic        prev_ss = 1'b1;
    logic        prev_sclk = 1'b1;
    logic [15:0] tx_word = 16'h0000;
    logic [15:0] rx_word = 16'h0000;
    logic [2:0]  prev_chnl = 3'd0;
    int          rise_cnt = 0;
    int          frame_cnt = 0;
    int          clk_cnt = 0;
    int          last_rise = 0;
    int          ss_high = 0;
    int          tx_idx = 0;

    // A2D slave model: returns the conversion of the channel addressed in the previous frame.
    always @(negedge clk) begin
        exp_t        e;
        logic [2:0]  cur;
        clk_cnt++;
        if (!rst_n) begin
            rise_cnt  = 0;
            frame_cnt = 0;
            ss_high   = 0;
            tx_idx    = 0;
            MISO      = 1'b0;
            sb_q.delete();
        end else begin
            if (SS_n) ss_high++;
            if (prev_ss && !SS_n) begin
                if (frame_cnt > 0) chk("ss_gap", 32'(ss_high >= 1), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("pot_update", 32'(out_of(int'(e.idx))), 32'(e.val));
                end
                tx_word  = {4'h0, pot_v[prev_chnl]};
                tx_idx   = 0;
                MISO     = tx_word[15];
                rise_cnt = 0;
                rx_word  = 16'h0000;
            end else if (!SS_n && !prev_sclk && SCLK) begin
                if (rise_cnt > 0) chk("sclk_period", 32'(clk_cnt - last_rise), 32'd32);
                last_rise = clk_cnt;
                rise_cnt++;
                rx_word = {rx_word[14:0], MOSI};
            end else if (!SS_n && prev_sclk && !SCLK && rise_cnt > 0) begin
                tx_idx++;
                MISO = (tx_idx < 16) ? tx_word[15 - tx_idx] : 1'b0;
            end else if (!prev_ss && SS_n) begin
                chk("rises_per_frame", 32'(rise_cnt), 32'd16);
                cur = order[(frame_cnt / 2) % 6];
                chk("cmd_word", 32'(rx_word), 32'({2'b00, cur, 11'h000}));
                if (frame_cnt % 2 == 1) begin
                    e.idx = 3'((frame_cnt / 2) % 6);
                    e.val = tx_word[11:0];
                    sb_q.push_back(e);
                end
                prev_chnl = rx_word[13:11];
                frame_cnt++;
                ss_high = 0;
            end
        end
        prev_ss   = SS_n;
        prev_sclk = SCLK;
    end

    task automatic release_and_check_start();
        int lat;
        lat = 99;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (!SS_n) begin
                lat = i;
                break;
            end
        end
        chk("first_start_clks", 32'(lat >= 1 && lat <= 2), 32'd1);
    endtask

    initial begin
        bit hit;
        set_pots(12'hA5C, 12'h123, 12'hFFF, 12'h000, 12'h7E1, 12'h801);

        // Reset held 30 clks.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("rst_pins", 32'({SS_n, SCLK, MOSI}), 32'(3'b110));
            chk("rst_pots", 32'(|{POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME}), 32'd0);
        end
        release_and_check_start();

        repeat (7000) @(negedge clk);
        check_all("directed_pots");

        for (int s = 0; s < 5; s++) begin
            set_pots(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                     12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                     12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
            repeat (7000) @(negedge clk);
            check_all("random_pots");
        end

        // Abort a frame at bit 7 with an asynchronous reset.
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (!SS_n && rise_cnt == 7) begin
                hit = 1'b1;
                break;
            end
        end
        chk("bit7_reached", 32'(hit), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_pins", 32'({SS_n, SCLK, MOSI}), 32'(3'b110));
        for (int i = 0; i < 6; i++) begin
            chk("abort_pots", 32'(out_of(i)), 32'd0);
        end
        repeat (10) @(negedge clk);
        release_and_check_start();
        repeat (7000) @(negedge clk);
        check_all("reconverge_pots");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
